// File: rtl/alu_operand_stage.sv
// alu_operand_stage: issue/writeback stage around an external 32-bit ALU.
// Ports:
//   clock, reset (async active-low)
//   in_*          upstream op handshake (op, rs, rt, rd, immediate select, immediate)
//   alu_*         operands/control to the ALU, result and flags back from it
//   out_*         downstream result handshake (data, rd, {overflow, zero, negative})
//   pre_*         preload write port into the register file
//   dbg_addr/data combinational register-file read
//   retired       count of completed output handshakes (wraps)
module alu_operand_stage #(
    parameter int NREGS = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic             in_use_imm,
    input  logic [15:0]      in_imm,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    output logic [2:0]       alu_control,
    input  logic [31:0]      alu_out,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_negative,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [4:0]       out_rd,
    output logic [2:0]       out_flags,
    input  logic             pre_wen,
    input  logic [4:0]       pre_addr,
    input  logic [31:0]      pre_data,
    input  logic [4:0]       dbg_addr,
    output logic [31:0]      dbg_data,
    output logic [CNT_W-1:0] retired
);
    logic [31:0] rf [NREGS];
    logic        e_valid, w_valid;
    logic [31:0] e_a, e_b;
    logic [2:0]  e_op;
    logic [4:0]  e_rd;
    logic        e_adv, w_adv, issue, wb_en;
    logic [31:0] src_a, src_b;
    assign w_adv    = w_valid & out_ready;
    assign e_adv    = e_valid & (!w_valid | w_adv);
    assign in_ready = !e_valid | e_adv;
    assign issue    = in_valid & in_ready;
    // Op codes 0 and 1 flow through but never write; rd=0 is never written.
    assign wb_en    = e_adv && e_rd != 5'd0 && e_op[2:1] != 2'b00;
    // Same-cycle writeback is forwarded so an issue never sees a stale value.
    always_comb begin
        src_a = in_rs == 5'd0 ? 32'd0 : (wb_en && e_rd == in_rs) ? alu_out : rf[in_rs];
        src_b = in_use_imm ? {{16{in_imm[15]}}, in_imm} :
                in_rt == 5'd0 ? 32'd0 : (wb_en && e_rd == in_rt) ? alu_out : rf[in_rt];
    end
    // Writeback is assigned last so it wins over a preload to the same address.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            if (pre_wen && pre_addr != 5'd0) rf[pre_addr] <= pre_data;
            if (wb_en) rf[e_rd] <= alu_out;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e_valid <= 1'b0;
            e_a     <= '0;
            e_b     <= '0;
            e_op    <= '0;
            e_rd    <= '0;
        end else if (issue) begin
            e_valid <= 1'b1;
            e_a     <= src_a;
            e_b     <= src_b;
            e_op    <= in_op;
            e_rd    <= in_rd;
        end else if (e_adv) begin
            e_valid <= 1'b0;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_valid   <= 1'b0;
            out_data  <= '0;
            out_rd    <= '0;
            out_flags <= '0;
        end else if (e_adv) begin
            w_valid   <= 1'b1;
            out_data  <= alu_out;
            out_rd    <= e_rd;
            out_flags <= {alu_overflow, alu_zero, alu_negative};
        end else if (w_adv) begin
            w_valid <= 1'b0;
        end
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) retired <= '0;
        else if (w_adv) retired <= retired + 1'b1;
    end
    assign alu_A       = e_a;
    assign alu_B       = e_b;
    assign alu_control = e_op;
    assign out_valid   = w_valid;
    assign dbg_data    = dbg_addr == 5'd0 ? 32'd0 : rf[dbg_addr];
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed self-checking bench with a behavioural ALU model.
module tb_alu_operand_stage;
    logic        clock, reset;
    logic        in_valid, in_ready, in_use_imm;
    logic [2:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [31:0] alu_A, alu_B, alu_out;
    logic [2:0]  alu_control;
    logic        alu_overflow, alu_zero, alu_negative;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [2:0]  out_flags;
    logic        pre_wen;
    logic [4:0]  pre_addr, dbg_addr;
    logic [31:0] pre_data, dbg_data;
    logic [15:0] retired;
    int tests = 0;
    int fails = 0;

    alu_operand_stage #(.NREGS(32), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_negative(alu_negative),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_flags(out_flags),
        .pre_wen(pre_wen), .pre_addr(pre_addr), .pre_data(pre_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural alu32: codes 0 and 1 pass A and B through.
    always_comb begin
        alu_out = alu_control == 3'd2 ? alu_A + alu_B :
                  alu_control == 3'd3 ? alu_A - alu_B :
                  alu_control == 3'd4 ? alu_A & alu_B :
                  alu_control == 3'd5 ? alu_A | alu_B :
                  alu_control == 3'd6 ? ~(alu_A | alu_B) :
                  alu_control == 3'd7 ? alu_A ^ alu_B :
                  alu_control == 3'd1 ? alu_B : alu_A;
        alu_overflow = alu_control == 3'd2 ? (alu_A[31] == alu_B[31]) && (alu_out[31] != alu_A[31]) :
                       alu_control == 3'd3 ? (alu_A[31] != alu_B[31]) && (alu_out[31] != alu_A[31]) : 1'b0;
        alu_zero     = alu_out == 32'd0;
        alu_negative = alu_out[31];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ui, input logic [15:0] imm);
        in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_use_imm = ui; in_imm = imm;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_wen = 1'b1; pre_addr = a; pre_data = d;
        tick;
        pre_wen = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            tests++;
            if (dbg_data !== 32'd0) begin
                fails++;
                $display("FAIL reset_dbg[%0d]: got %h expected 0", i, dbg_data);
            end
        end
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || retired !== 16'd0 || out_data !== 32'd0 ||
            alu_A !== 32'd0 || alu_B !== 32'd0 || alu_control !== 3'd0) begin
            fails++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b retired=%0d out_data=%h alu_A=%h expected 1 0 0 0 0",
                     in_ready, out_valid, retired, out_data, alu_A);
        end
        out_ready = 1'b0;
        drive(3'd2, 5'd0, 5'd0, 5'd1, 1'b1, 16'd9);
        tick;
        drive(3'd2, 5'd0, 5'd0, 5'd2, 1'b1, 16'd7);
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL inflight_valid: got %b expected 1", out_valid);
        end
        reset = 1'b0;
        dbg_addr = 5'd1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || alu_A !== 32'd0 || alu_B !== 32'd0 || dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL midop_reset: out_valid=%b in_ready=%b alu_A=%h alu_B=%h reg1=%h expected 0 1 0 0 0",
                     out_valid, in_ready, alu_A, alu_B, dbg_data);
        end
        reset = 1'b1;
        out_ready = 1'b1;
        tick;
    endtask

    task automatic test_add_forward;
        drive(3'd2, 5'd0, 5'd0, 5'd1, 1'b1, 16'd5);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL add_in_ready: got %b expected 1", in_ready);
        end
        tick;
        drive(3'd2, 5'd1, 5'd0, 5'd2, 1'b1, 16'hFFFF);
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd5 || out_rd !== 5'd1 || out_flags !== 3'b000) begin
            fails++;
            $display("FAIL add_first: valid=%b data=%h rd=%0d flags=%b expected 1 5 1 000",
                     out_valid, out_data, out_rd, out_flags);
        end
        tick;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd4 || out_rd !== 5'd2 || out_flags !== 3'b000) begin
            fails++;
            $display("FAIL add_forward: valid=%b data=%h rd=%0d flags=%b expected 1 4 2 000",
                     out_valid, out_data, out_rd, out_flags);
        end
        dbg_addr = 5'd1;
        #1;
        tests++;
        if (dbg_data !== 32'd5) begin
            fails++;
            $display("FAIL add_reg1: got %h expected 5", dbg_data);
        end
        dbg_addr = 5'd2;
        #1;
        tests++;
        if (dbg_data !== 32'd4) begin
            fails++;
            $display("FAIL add_reg2: got %h expected 4", dbg_data);
        end
    endtask

    task automatic test_sub_zero;
        preload(5'd3, 32'hFF);
        drive(3'd3, 5'd1, 5'd1, 5'd3, 1'b0, 16'd0);
        tick;
        in_valid = 1'b0;
        tick;
        tests++;
        if (out_data !== 32'd0 || out_flags !== 3'b010 || out_rd !== 5'd3) begin
            fails++;
            $display("FAIL sub_zero: data=%h flags=%b rd=%0d expected 0 010 3", out_data, out_flags, out_rd);
        end
        dbg_addr = 5'd3;
        #1;
        tests++;
        if (dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL sub_reg3: got %h expected 0", dbg_data);
        end
    endtask

    task automatic test_overflow;
        preload(5'd4, 32'h7FFFFFFF);
        drive(3'd2, 5'd4, 5'd0, 5'd5, 1'b1, 16'd1);
        tick;
        in_valid = 1'b0;
        tick;
        tests++;
        if (out_data !== 32'h80000000 || out_flags !== 3'b101) begin
            fails++;
            $display("FAIL overflow: data=%h flags=%b expected 80000000 101", out_data, out_flags);
        end
        dbg_addr = 5'd5;
        #1;
        tests++;
        if (dbg_data !== 32'h80000000) begin
            fails++;
            $display("FAIL overflow_reg5: got %h expected 80000000", dbg_data);
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        preload(5'd1, 32'd10);
        out_ready = 1'b0;
        drive(3'd2, 5'd1, 5'd0, 5'd7, 1'b1, 16'd1);
        tick;
        drive(3'd2, 5'd1, 5'd0, 5'd8, 1'b1, 16'd2);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_second_ready: got %b expected 1", in_ready);
        end
        tick;
        drive(3'd2, 5'd1, 5'd0, 5'd9, 1'b1, 16'd3);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_stall_ready: got %b expected 0", in_ready);
        end
        tick;
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd11) begin
            fails++;
            $display("FAIL bp_hold: in_ready=%b valid=%b data=%h expected 0 1 0000000b", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_data !== 32'd12 || out_rd !== 5'd8) begin
            fails++;
            $display("FAIL bp_order2: data=%h rd=%0d expected 0000000c 8", out_data, out_rd);
        end
        tick;
        tests++;
        if (out_data !== 32'd13 || out_rd !== 5'd9) begin
            fails++;
            $display("FAIL bp_order3: data=%h rd=%0d expected 0000000d 9", out_data, out_rd);
        end
        tick;
        tests++;
        if (out_valid !== 1'b0 || retired !== 16'd3) begin
            fails++;
            $display("FAIL bp_retired: valid=%b retired=%0d expected 0 3", out_valid, retired);
        end
        dbg_addr = 5'd9;
        #1;
        tests++;
        if (dbg_data !== 32'd13) begin
            fails++;
            $display("FAIL bp_reg9: got %h expected 0000000d", dbg_data);
        end
    endtask

    task automatic test_no_write;
        preload(5'd6, 32'h66);
        drive(3'd7, 5'd1, 5'd0, 5'd0, 1'b1, 16'd3);
        tick;
        drive(3'd1, 5'd1, 5'd0, 5'd6, 1'b1, 16'h1234);
        tick;
        in_valid = 1'b0;
        tests++;
        if (out_data !== 32'd9 || out_rd !== 5'd0) begin
            fails++;
            $display("FAIL xor_rd0: data=%h rd=%0d expected 9 0", out_data, out_rd);
        end
        tick;
        tests++;
        if (out_data !== 32'h1234 || out_rd !== 5'd6 || out_flags !== 3'b000) begin
            fails++;
            $display("FAIL op1_pass: data=%h rd=%0d flags=%b expected 1234 6 000", out_data, out_rd, out_flags);
        end
        dbg_addr = 5'd0;
        #1;
        tests++;
        if (dbg_data !== 32'd0) begin
            fails++;
            $display("FAIL reg0: got %h expected 0", dbg_data);
        end
        dbg_addr = 5'd6;
        #1;
        tests++;
        if (dbg_data !== 32'h66) begin
            fails++;
            $display("FAIL reg6_kept: got %h expected 66", dbg_data);
        end
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_use_imm = 1'b0; in_imm = '0; out_ready = 1'b1;
        pre_wen = 1'b0; pre_addr = '0; pre_data = '0; dbg_addr = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        test_reset;
        test_add_forward;
        test_sub_zero;
        test_overflow;
        test_back_to_back;
        test_no_write;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
